bcm_display_driver: RTL
=======================

Name: bcm_display_driver

Overview:
- Binary-coded-modulation (BCM) successor to the PWM row/column LED panel driver.
- Per row, shifts one bit-plane per display period instead of 2^bitwidth PWM compare passes. Plane p is displayed for base_cycles<<p clocks.
- Shifting of the next plane overlaps display of the current plane. Adds a global brightness control and separate memory-address and panel row outputs.
- Sits between the frame-buffer BRAM (pixel already gamma-corrected) and the panel pins.

Parameters:
- load_delay, 1, clocks from column/addr_row/plane change to valid pixel; minimum 1.
- segments, 1, parallel RGB segments (panel halves).
- rows, 8, addressable rows.
- columns, 32, pixels shifted per row.
- bitwidth, 8, bits per colour channel (bit-planes).
- base_cycles, 16, display clocks for plane 0; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  run frames; sampled at frame start
- brightness  in  8  global dim, on-time scale (value+1)/256
- pixel  in  bitwidth*3*segments  pixel for {addr_row, column}; segment i, channel c (R=0, G=1, B=2) at bit offset bitwidth*(3i+c)
- addr_row  out  clog2(rows)  row being shifted (to memory)
- column  out  clog2(columns)  column being shifted (to memory)
- plane  out  clog2(bitwidth)  bit-plane being shifted
- rgb  out  3*segments  serial data to panel
- oclk  out  1  panel shift clock
- lat  out  1  panel latch, one-clock pulse
- oe  out  1  panel output enable, active-high
- row  out  clog2(rows)  panel row select (displayed row)
- frame_complete  out  1  one-clock pulse per finished frame

Behaviour:
- Reset: all outputs 0; shift FSM in IDLE; display timer idle. Reset mid-operation aborts immediately, with oe=0 on the next edge.
- rgb bit mapping: rgb[3i+c] = pixel[bitwidth*(3i+c) + plane], registered.
- Shift FSM states: IDLE, ADDR, SAMPLE, CLKHI, WAITDISP, LATCH.
  - IDLE: when enable=1, set addr_row=0, plane=0, column=0, then go to ADDR.
  - ADDR: column/addr_row/plane stable for load_delay clocks; oclk=0.
  - SAMPLE: rgb <= selected plane bits; oclk=0.
  - CLKHI: oclk=1 for one clock. If column==columns-1, go to WAITDISP. Otherwise column++ and go to ADDR.
  - One column therefore takes load_delay+2 clocks; a plane takes columns*(load_delay+2) clocks.
  - WAITDISP: wait until the display timer is idle. oclk=0; rgb holds.
  - LATCH: one clock with lat=1 and oe=0. row <= addr_row. Display timer is loaded with period=base_cycles<<plane and on=(period*(brightness+1))>>8.
  - After LATCH, advance plane. On wrap, plane=0 and addr_row++.
  - If addr_row wraps from rows-1, pulse frame_complete in the LATCH cycle. Then go to ADDR if enable=1, else IDLE.
- Display timer: elapsed counter e runs 0..period-1.
  - oe=1 while e<on, else 0. on=0 keeps oe low the whole period.
  - Timer is idle once e reaches period; oe=0 when idle.
  - Timer width must hold base_cycles<<(bitwidth-1) without overflow; the product uses a width-extended multiply.
- Overlap: the first ADDR of the next plane starts the clock after LATCH, while the timer runs. If shifting finishes first, WAITDISP stalls. If the timer finishes first, oe stays 0 until LATCH.
- row changes only in LATCH (oe=0), so there is no ghosting on row transitions.
- enable deasserted mid-frame: the frame finishes. After the last LATCH, the FSM goes to IDLE; the last plane still displays its full period, then oe=0.
- brightness is sampled only in LATCH; changes mid-period take effect next plane.

Test Plan:
- Reset: hold rst 3 clocks during active shifting -> next edge oe=0, lat=0, oclk=0, rgb=0, row=0, frame_complete=0; after release with enable=0 all stay 0.
- Shift timing (columns=4, load_delay=2, bitwidth=2, rows=2, base_cycles=64):
  - oclk high exactly every 4 clocks, 4 pulses, lat one-clock pulse after the 4th.
  - rgb equals bit 0 of each pixel, then bit 1 of each pixel in the next plane.
- Plane durations (brightness=255, base_cycles=16, bitwidth=3): oe high 16, 32, 64 clocks after successive latches; row updates only on lat cycles.
- Brightness (base_cycles=16, plane 2): brightness=127 -> oe high 32 of 64 clocks; brightness=0 -> 0 clocks.
- Frame (rows=2, bitwidth=2): frame_complete pulses once per 4 latches; addr_row sequence 0,0,1,1.
- Enable low mid-row 0 -> frame completes (pulse seen); the last plane displays its full period; then oclk, lat and oe stay 0.

Source files
------------

// File: rtl/bcm_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : bcm_display_driver
// Purpose  : Binary-coded-modulation row/column LED panel driver. For each
//            row, every bit-plane is shifted out serially and then displayed
//            for BASE_CYCLES << plane clocks, scaled by a global brightness.
//            Shifting of the next plane overlaps display of the current one.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            enable            - run frames (sampled at frame start)
//            brightness        - global on-time scale (value+1)/256
//            pixel             - frame-buffer word for {addr_row, column}
//            addr_row, column, plane - frame-buffer / plane addressing
//            rgb, oclk, lat    - serial data, shift clock, latch pulse
//            oe, row           - output enable (active-high), displayed row
//            frame_complete    - one-clock pulse per finished frame
// Revision : 1.0 - initial release
// ============================================================================
module bcm_display_driver #(
    parameter int LOAD_DELAY  = 1,
    parameter int SEGMENTS    = 1,
    parameter int ROWS        = 8,
    parameter int COLUMNS     = 32,
    parameter int BITWIDTH    = 8,
    parameter int BASE_CYCLES = 16,
    localparam int c_row_w    = (ROWS > 1)     ? $clog2(ROWS)     : 1,
    localparam int c_col_w    = (COLUMNS > 1)  ? $clog2(COLUMNS)  : 1,
    localparam int c_plane_w  = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [7:0]                       brightness,
    input  logic [BITWIDTH*3*SEGMENTS-1:0]   pixel,
    output logic [c_row_w-1:0]               addr_row,
    output logic [c_col_w-1:0]               column,
    output logic [c_plane_w-1:0]             plane,
    output logic [3*SEGMENTS-1:0]            rgb,
    output logic                             oclk,
    output logic                             lat,
    output logic                             oe,
    output logic [c_row_w-1:0]               row,
    output logic                             frame_complete
);

    localparam int c_delay_w    = (LOAD_DELAY > 1) ? $clog2(LOAD_DELAY) : 1;
    localparam int c_max_period = BASE_CYCLES << (BITWIDTH - 1);
    // Timer must be able to hold the longest period itself (elapsed == period).
    localparam int c_tmr_w      = $clog2(c_max_period + 1);
    localparam int c_prod_w     = c_tmr_w + 9;

    localparam logic [c_delay_w-1:0] c_delay_last = c_delay_w'(LOAD_DELAY - 1);
    localparam logic [c_col_w-1:0]   c_col_last   = c_col_w'(COLUMNS - 1);
    localparam logic [c_row_w-1:0]   c_row_last   = c_row_w'(ROWS - 1);
    localparam logic [c_plane_w-1:0] c_plane_last = c_plane_w'(BITWIDTH - 1);
    localparam logic [c_tmr_w-1:0]   c_base       = c_tmr_w'(BASE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_SAMPLE   = 3'd2,
        S_CLKHI    = 3'd3,
        S_WAITDISP = 3'd4,
        S_LATCH    = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_delay_w-1:0]   r_delay;
    logic [c_delay_w-1:0]   w_delay_nxt;
    logic [c_row_w-1:0]     w_addr_row_nxt;
    logic [c_col_w-1:0]     w_column_nxt;
    logic [c_plane_w-1:0]   w_plane_nxt;
    logic                   w_frame_end;
    logic [3*SEGMENTS-1:0]  w_plane_bits;

    logic                   r_busy;
    logic [c_tmr_w-1:0]     r_elapsed;
    logic [c_tmr_w-1:0]     r_period;
    logic [c_prod_w-1:0]    r_on;
    logic [c_tmr_w-1:0]     w_period;
    logic [c_tmr_w-1:0]     w_elapsed_inc;
    logic [8:0]             w_bright_p1;
    logic [c_prod_w-1:0]    w_on;

    // Select the current plane bit of every segment/channel.
    genvar gi, gc;
    generate
        for (gi = 0; gi < SEGMENTS; gi++) begin : g_seg
            for (gc = 0; gc < 3; gc++) begin : g_chan
                logic [BITWIDTH-1:0] w_chan;
                assign w_chan = pixel[BITWIDTH*(3*gi+gc) +: BITWIDTH];
                assign w_plane_bits[3*gi+gc] = w_chan[plane];
            end
        end
    endgenerate

    // The plane now being latched is the last one of the frame.
    assign w_frame_end = (plane == c_plane_last) && (addr_row == c_row_last);

    // ---------------- shift FSM: next state ----------------
    always_comb begin
        w_state_nxt    = r_state;
        w_delay_nxt    = r_delay;
        w_addr_row_nxt = addr_row;
        w_column_nxt   = column;
        w_plane_nxt    = plane;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_addr_row_nxt = '0;
                    w_plane_nxt    = '0;
                    w_column_nxt   = '0;
                    w_delay_nxt    = '0;
                    w_state_nxt    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (r_delay == c_delay_last) begin
                    w_delay_nxt = '0;
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_delay_nxt = r_delay + 1'b1;
                end
            end
            S_SAMPLE: w_state_nxt = S_CLKHI;
            S_CLKHI: begin
                if (column == c_col_last) begin
                    w_state_nxt = S_WAITDISP;
                end else begin
                    w_column_nxt = column + 1'b1;
                    w_state_nxt  = S_ADDR;
                end
            end
            S_WAITDISP: begin
                if (!r_busy) w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_column_nxt = '0;
                if (plane == c_plane_last) begin
                    w_plane_nxt    = '0;
                    w_addr_row_nxt = (addr_row == c_row_last) ? '0 : addr_row + 1'b1;
                end else begin
                    w_plane_nxt = plane + 1'b1;
                end
                // Enable only stops the driver at a frame boundary.
                w_state_nxt = (w_frame_end && !enable) ? S_IDLE : S_ADDR;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- shift FSM: registers and panel strobes ----------------
    // Strobes are decoded from the next state so they are glitch-free flops
    // that are high exactly during the CLKHI / LATCH cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_delay        <= '0;
            addr_row       <= '0;
            column         <= '0;
            plane          <= '0;
            rgb            <= '0;
            oclk           <= 1'b0;
            lat            <= 1'b0;
            row            <= '0;
            frame_complete <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_delay        <= w_delay_nxt;
            addr_row       <= w_addr_row_nxt;
            column         <= w_column_nxt;
            plane          <= w_plane_nxt;
            oclk           <= (w_state_nxt == S_CLKHI);
            lat            <= (w_state_nxt == S_LATCH);
            frame_complete <= (w_state_nxt == S_LATCH) && w_frame_end;
            if (w_state_nxt == S_LATCH) row <= addr_row;
            if (r_state == S_SAMPLE) rgb <= w_plane_bits;
        end
    end

    // ---------------- display timer ----------------
    assign w_period      = c_base << plane;
    assign w_elapsed_inc = r_elapsed + 1'b1;
    assign w_bright_p1   = {1'b0, brightness} + 9'd1;
    // Full-width product so that period*(brightness+1) never overflows.
    assign w_on = ({9'd0, w_period} * {{c_tmr_w{1'b0}}, w_bright_p1}) >> 8;

    // Loaded at the end of the LATCH cycle so oe stays low while lat is high;
    // oe is then high for the first 'on' of the 'period' elapsed clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_elapsed <= '0;
            r_period  <= '0;
            r_on      <= '0;
            oe        <= 1'b0;
        end else if (r_state == S_LATCH) begin
            r_busy    <= 1'b1;
            r_elapsed <= '0;
            r_period  <= w_period;
            r_on      <= w_on;
            oe        <= (w_on != '0);
        end else if (r_busy) begin
            r_elapsed <= w_elapsed_inc;
            if (w_elapsed_inc == r_period) begin
                r_busy <= 1'b0;
                oe     <= 1'b0;
            end else begin
                oe <= ({9'd0, w_elapsed_inc} < r_on);
            end
        end else begin
            oe <= 1'b0;
        end
    end

endmodule
`default_nettype wire
